pla_fitness_evaluator: RTL

Exhaustive-sweep response checker for the combinational PLA benchmarks. It drives every input pattern `0 .. 2^N_IN-1` into a candidate circuit (evolved netlist) and into the golden benchmark in parallel. It compares their `po` vectors under a mask and accumulates the total bit-mismatch count, which is the CGP fitness figure. The block is the consuming end of the benchmark interface: the benchmark writes `po`, and this block reads and scores it.

---
 rtl/pla_fitness_evaluator.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pla_fitness_evaluator.sv
// pla_fitness_evaluator
//   Exhaustive-sweep response checker. It drives every pattern 0 .. 2^N_IN-1 on pi_o
//   to a candidate circuit and to a golden circuit at the same time. It then counts the
//   masked bit mismatches between their po vectors, which gives the CGP fitness figure.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start             : begin a sweep (accepted in idle only)
//   abort             : cancel a sweep in progress
//   out_mask          : scored output bits, latched when start is accepted
//   pi_o              : pattern driven to both circuits
//   dut_po, ref_po    : candidate / golden outputs (combinational from pi_o)
//   busy, done        : sweep in progress / one-cycle completion pulse
//   result_valid      : result outputs below hold a completed sweep
//   err_count         : saturating total of masked mismatched bits
//   fail_patterns     : patterns with at least one masked mismatch
//   first_fail(_valid): lowest failing pattern
module pla_fitness_evaluator #(
  parameter int unsigned N_IN  = 12,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned ERR_W = 16,
  parameter int unsigned PIPE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] out_mask,
  output logic [N_IN-1:0]  pi_o,
  input  logic [N_OUT-1:0] dut_po,
  input  logic [N_OUT-1:0] ref_po,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN:0]    fail_patterns,
  output logic [N_IN-1:0]  first_fail,
  output logic             first_fail_valid
);

  localparam int unsigned CntW  = $clog2(N_OUT + 1);
  localparam int unsigned SumW  = ERR_W + 1;
  localparam int unsigned FailW = N_IN + 1;
  localparam bit          Piped = (PIPE != 0);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [N_IN-1:0]  PatLast = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]  PatOne  = N_IN'(1);
  localparam logic [N_IN:0]    FailOne = FailW'(1);

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  pi_q, pi_d;
  logic [N_OUT-1:0] mask_q, mask_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N_IN:0]    fail_q, fail_d;
  logic [N_IN-1:0]  ff_q, ff_d;
  logic             ffv_q, ffv_d;
  logic             rv_q, rv_d;

  // Compare source: live po values, or the previous cycle's registered copies.
  logic             cmp_en;
  logic [N_OUT-1:0] cmp_dut;
  logic [N_OUT-1:0] cmp_ref;
  logic [N_IN-1:0]  cmp_pat;

  if (Piped) begin : g_pipe
    logic [N_OUT-1:0] dut_q;
    logic [N_OUT-1:0] ref_q;
    logic [N_IN-1:0]  pat_q;
    logic             vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dut_q <= '0;
        ref_q <= '0;
        pat_q <= '0;
        vld_q <= 1'b0;
      end else begin
        dut_q <= dut_po;
        ref_q <= ref_po;
        pat_q <= pi_q;
        // Only copies taken during a sweep cycle are scored.
        vld_q <= (state_q == StSweep);
      end
    end

    assign cmp_dut = dut_q;
    assign cmp_ref = ref_q;
    assign cmp_pat = pat_q;
    assign cmp_en  = vld_q && ((state_q == StSweep) || (state_q == StFlush));
  end else begin : g_nopipe
    assign cmp_dut = dut_po;
    assign cmp_ref = ref_po;
    assign cmp_pat = pi_q;
    assign cmp_en  = (state_q == StSweep);
  end

  logic [N_OUT-1:0] diff;
  logic [CntW-1:0]  pop;
  logic [SumW-1:0]  err_sum;

  assign diff = (cmp_dut ^ cmp_ref) & mask_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_OUT; i++) begin
      pop = pop + CntW'(diff[i]);
    end
  end

  assign err_sum = {1'b0, err_q} + SumW'(pop);

  always_comb begin
    state_d = state_q;
    pi_d    = pi_q;
    mask_d  = mask_q;
    err_d   = err_q;
    fail_d  = fail_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    rv_d    = rv_q;

    if (cmp_en && !abort) begin
      err_d = err_sum[SumW-1] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
      if (diff != '0) begin
        fail_d = fail_q + FailOne;
        if (!ffv_q) begin
          ff_d  = cmp_pat;
          ffv_d = 1'b1;
        end
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSweep;
          pi_d    = '0;
          mask_d  = out_mask;
          err_d   = '0;
          fail_d  = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          rv_d    = 1'b0;
        end
      end
      StSweep: begin
        if (abort) begin
          state_d = StIdle;
          pi_d    = '0;
        end else if (pi_q == PatLast) begin
          pi_d    = '0;
          state_d = Piped ? StFlush : StDone;
          rv_d    = !Piped;
        end else begin
          pi_d = pi_q + PatOne;
        end
      end
      StFlush: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          rv_d    = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pi_q    <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pi_q    <= pi_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      rv_q    <= rv_d;
    end
  end

  assign pi_o             = pi_q;
  assign busy             = (state_q == StSweep) || (state_q == StFlush);
  assign done             = (state_q == StDone);
  assign result_valid     = rv_q;
  assign err_count        = err_q;
  assign fail_patterns    = fail_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule
